hififo_pio_ctrl: RTL and testbench
==================================

Name: hififo_pio_ctrl

Overview:
Parametrised PIO register and interrupt controller for the HIFIFO PCIe bridge. It replaces the fixed 8-FIFO register decode, per-FIFO interrupt counters and fifo_reset logic with one block of NFIFO channels. It adds an interrupt mask, a read-to-clear pending register, per-channel arm/disarm, and ENABLE-qualified reset bits. It sits between pcie_rx (PIO requests), pcie_tx (read completion data) and the FIFO instances (count inputs, reset outputs).

Parameters:
NFIFO, 8, number of FIFO channels, 1..16
ENABLE, 16'h0011, bit i set = channel i instantiated; bits at or above NFIFO are ignored
NBITS, 29, compared width of the threshold and count, 1..32
VERSION, 8'h02, returned in the ID register

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high (pci_reset)
pio_wvalid  in  1  PIO write strobe, one cycle
pio_rvalid  in  1  PIO read strobe, one cycle
pio_addr  in  6  64-bit word index
pio_wdata  in  64  write data
rc_done  out  1  read completion data valid
rc_data  out  32  read completion data
fifo_reset  out  NFIFO  per-FIFO reset
count  in  32*NFIFO  per-channel transfer count, channel i at [32i+31:32i]
interrupt  out  1  interrupt request to core
interrupt_rdy  in  1  core has accepted the interrupt

Behaviour:
- Register map (addr: write / read):
  - 0: none / pending[NFIFO-1:0], read clears pending.
  - 1: none / ENABLE.
  - 2: mask <= wdata[NFIFO-1:0] / mask.
  - 3: fifo_reset |= wdata / fifo_reset.
  - 4: fifo_reset &= ~wdata / fifo_reset.
  - 5: none / {8'h0, VERSION, 8'h0, 8'(NFIFO)}.
  - 32+2i: threshold[i] <= wdata[NBITS-1:0] and armed[i] <= 1 / count[i].
  - All other addresses: writes ignored, reads return 0.
- Read latency: rc_done asserts exactly 1 cycle after pio_rvalid, and rc_data is valid in that same cycle. rc_data is held between reads.
- If pio_wvalid and pio_rvalid assert in the same cycle, the write takes effect and the read returns the pre-write value.
- Disabled channel i (ENABLE[i]=0 or i>=NFIFO):
  - fifo_reset[i], pending[i] and armed[i] are constant 0.
  - Threshold writes are ignored.
  - count reads return 0.
  - count[i] is not used.
- Channel match: hit[i] = armed[i] & (count[i][NBITS-1:0] == threshold[i]).
  - On hit: pending[i] <= 1 and armed[i] <= 0. A channel fires once per arm.
  - A threshold write in the same cycle as a hit re-arms the channel (armed=1, new threshold) and still sets pending.
  - If the write value already equals count, hit occurs on the following cycle.
- Pending clear: an addr-0 read clears pending in the cycle after the strobe. A bit set in that same cycle stays set (set wins) and is not included in the returned value.
- new_evt = |(hit & mask & ENABLE).
- interrupt <= new_evt | (interrupt & ~interrupt_rdy). It stays high until interrupt_rdy is sampled high. An event coinciding with interrupt_rdy keeps it high.
- Reset values:
  - fifo_reset = ENABLE[NFIFO-1:0]
  - mask = ENABLE[NFIFO-1:0]
  - pending = 0, armed = 0, threshold = 0
  - interrupt = 0, rc_done = 0, rc_data = 0
- Reset mid-operation: a read strobed in the cycle before reset asserts produces no rc_done. A pending interrupt is dropped.
- Width rules:
  - Only wdata[NFIFO-1:0] is used for the mask/set/clear registers.
  - Only wdata[NBITS-1:0] is used for threshold.
  - Upper count bits are ignored in the compare but returned on read.

Test Plan:
- Defaults NFIFO=8, ENABLE=8'h11.
  - Release reset, read addr 3 -> rc_done at +1 cycle, rc_data=0x11.
  - Write 4 wdata=0xFF -> fifo_reset=0x00.
  - Write 3 wdata=0xFF -> fifo_reset=0x11 (disabled bits stay 0).
- Write 32 wdata=100, ramp count[0] 0..120 -> single interrupt at count 100, held until interrupt_rdy.
  - Read 0 -> 0x01.
  - Second read 0 -> 0x00.
  - No further interrupt at count 100+ without a re-arm.
- Write mask=0, arm ch4 (addr 40) with threshold=count -> pending[4]=1, interrupt stays 0.
  - Read 0 -> 0x10.
- Hit on ch0 in the same cycle as the addr-0 read completes its clear -> read returns 0x00, next read returns 0x01.
- Write addr 34 (ch1, disabled) -> no effect. Read 34 -> 0. Read 5 -> 0x00020008. Read addr 63 -> 0.
- Assert reset with interrupt high and a read strobed in the preceding cycle -> interrupt=0, rc_done never pulses, fifo_reset=0x11, mask=0x11.

Source files
------------

// File: rtl/hififo_pio_ctrl.sv
// rtl/hififo_pio_ctrl.sv - PIO register decode, per-channel threshold interrupts and FIFO reset control
module hififo_pio_ctrl #(
    parameter int          NFIFO   = 8,
    parameter logic [15:0] ENABLE  = 16'h0011,
    parameter int          NBITS   = 29,
    parameter logic [7:0]  VERSION = 8'h02
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pio_wvalid,
    input  logic                 pio_rvalid,
    input  logic [5:0]           pio_addr,
    input  logic [63:0]          pio_wdata,
    output logic                 rc_done,
    output logic [31:0]          rc_data,
    output logic [NFIFO-1:0]     fifo_reset,
    input  logic [32*NFIFO-1:0]  count,
    output logic                 interrupt,
    input  logic                 interrupt_rdy
);

    localparam logic [NFIFO-1:0] EN = ENABLE[NFIFO-1:0];

    logic [NFIFO-1:0] mask;
    logic [NFIFO-1:0] pending;
    logic [NFIFO-1:0] armed;
    logic [NFIFO-1:0] hit;
    logic [NFIFO-1:0] thr_wr;
    logic [NBITS-1:0] threshold [NFIFO];
    logic [31:0]      rd_mux;
    logic             rd_clear;
    logic             new_evt;
    logic             rc_done_q;
    logic             unused_inputs;

    // Upper wdata bits and disabled-channel counts are deliberately ignored.
    assign unused_inputs = &{1'b0, pio_wdata, count};

    always_comb begin
        hit    = '0;
        thr_wr = '0;
        for (int i = 0; i < NFIFO; i++) begin
            hit[i]    = EN[i] & armed[i] & (count[32*i +: NBITS] == threshold[i]);
            thr_wr[i] = EN[i] & pio_wvalid & (pio_addr == 6'(32 + 2*i));
        end
    end

    assign new_evt  = |(hit & mask & EN);
    assign rd_clear = pio_rvalid & (pio_addr == 6'd0);

    always_comb begin
        rd_mux = '0;
        case (pio_addr)
            6'd0:       rd_mux = 32'(pending);
            6'd1:       rd_mux = 32'(ENABLE);
            6'd2:       rd_mux = 32'(mask);
            6'd3, 6'd4: rd_mux = 32'(fifo_reset);
            6'd5:       rd_mux = {8'h00, VERSION, 8'h00, 8'(NFIFO)};
            default: begin
                for (int i = 0; i < NFIFO; i++) begin
                    if (EN[i] && pio_addr == 6'(32 + 2*i)) begin
                        rd_mux = count[32*i +: 32];
                    end
                end
            end
        endcase
    end

    // A read still in flight when reset arrives must not complete.
    assign rc_done = rc_done_q & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            fifo_reset <= EN;
            mask       <= EN;
            pending    <= '0;
            armed      <= '0;
            interrupt  <= 1'b0;
            rc_done_q  <= 1'b0;
            rc_data    <= '0;
            for (int i = 0; i < NFIFO; i++) begin
                threshold[i] <= '0;
            end
        end else begin
            rc_done_q <= pio_rvalid;
            if (pio_rvalid) begin
                rc_data <= rd_mux;
            end

            if (pio_wvalid) begin
                case (pio_addr)
                    6'd2: mask       <= pio_wdata[NFIFO-1:0];
                    6'd3: fifo_reset <= (fifo_reset | pio_wdata[NFIFO-1:0]) & EN;
                    6'd4: fifo_reset <= fifo_reset & ~pio_wdata[NFIFO-1:0];
                    default: ;
                endcase
            end

            // Only bits already reported are cleared; a same-cycle hit survives.
            pending <= ((rd_clear ? '0 : pending) | hit) & EN;

            for (int i = 0; i < NFIFO; i++) begin
                if (thr_wr[i]) begin
                    threshold[i] <= pio_wdata[NBITS-1:0];
                    armed[i]     <= 1'b1;
                end else if (hit[i]) begin
                    armed[i] <= 1'b0;
                end
            end

            interrupt <= new_evt | (interrupt & ~interrupt_rdy);
        end
    end

endmodule

// File: tb/tb_hififo_pio_ctrl.sv
// tb/tb_hififo_pio_ctrl.sv - directed self-checking bench for hififo_pio_ctrl
module tb_hififo_pio_ctrl;

    logic         clock = 1'b0;
    logic         reset;
    logic         pio_wvalid;
    logic         pio_rvalid;
    logic [5:0]   pio_addr;
    logic [63:0]  pio_wdata;
    logic         rc_done;
    logic [31:0]  rc_data;
    logic [7:0]   fifo_reset;
    logic [255:0] count;
    logic         interrupt;
    logic         interrupt_rdy;

    int checks = 0;
    int passed = 0;

    hififo_pio_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .pio_wvalid    (pio_wvalid),
        .pio_rvalid    (pio_rvalid),
        .pio_addr      (pio_addr),
        .pio_wdata     (pio_wdata),
        .rc_done       (rc_done),
        .rc_data       (rc_data),
        .fifo_reset    (fifo_reset),
        .count         (count),
        .interrupt     (interrupt),
        .interrupt_rdy (interrupt_rdy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [63:0] d);
        pio_wvalid = 1'b1;
        pio_addr   = a;
        pio_wdata  = d;
        tick();
        pio_wvalid = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [31:0] d, output logic done);
        pio_rvalid = 1'b1;
        pio_addr   = a;
        tick();
        pio_rvalid = 1'b0;
        done = rc_done;
        d    = rc_data;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        done;
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (fifo_reset !== 8'h11) $display("FAIL reset_fifo_reset got %h want 11", fifo_reset); else passed++;
        checks++; if (interrupt !== 1'b0 || rc_done !== 1'b0 || rc_data !== 32'h0)
            $display("FAIL reset_outputs got int=%b done=%b data=%h want 0/0/0", interrupt, rc_done, rc_data); else passed++;
        reset = 1'b0;
        do_read(6'd3, d, done);
        checks++; if (done !== 1'b1 || d !== 32'h11) $display("FAIL read3_latency got done=%b data=%h want 1/00000011", done, d); else passed++;
        tick();
        checks++; if (rc_done !== 1'b0 || rc_data !== 32'h11) $display("FAIL rc_done_pulse got done=%b data=%h want 0/00000011", rc_done, rc_data); else passed++;
        do_read(6'd2, d, done);
        checks++; if (d !== 32'h11) $display("FAIL reset_mask got %h want 00000011", d); else passed++;
        do_read(6'd0, d, done);
        checks++; if (d !== 32'h0) $display("FAIL reset_pending got %h want 0", d); else passed++;
    endtask

    task automatic test_fifo_reset();
        do_write(6'd4, 64'hFF);
        checks++; if (fifo_reset !== 8'h00) $display("FAIL fifo_reset_clear got %h want 00", fifo_reset); else passed++;
        do_write(6'd3, 64'hFF);
        checks++; if (fifo_reset !== 8'h11) $display("FAIL fifo_reset_set got %h want 11", fifo_reset); else passed++;
    endtask

    task automatic test_threshold();
        logic [31:0] d;
        logic        done;
        int          first;
        int          late;
        first = -1;
        count[31:0] = 32'd0;
        do_write(6'd32, 64'd100);
        for (int k = 0; k <= 120; k++) begin
            count[31:0] = 32'(k);
            tick();
            if (interrupt && first < 0) first = k;
        end
        checks++; if (first !== 100) $display("FAIL threshold_fire got first=%0d want 100", first); else passed++;
        checks++; if (interrupt !== 1'b1) $display("FAIL interrupt_held got %b want 1", interrupt); else passed++;
        interrupt_rdy = 1'b1;
        tick();
        interrupt_rdy = 1'b0;
        checks++; if (interrupt !== 1'b0) $display("FAIL interrupt_ack got %b want 0", interrupt); else passed++;
        do_read(6'd0, d, done);
        checks++; if (d !== 32'h01) $display("FAIL pending_ch0 got %h want 00000001", d); else passed++;
        do_read(6'd0, d, done);
        checks++; if (d !== 32'h00) $display("FAIL pending_cleared got %h want 0", d); else passed++;
        late = 0;
        count[31:0] = 32'd100;
        repeat (4) begin
            tick();
            if (interrupt) late++;
        end
        do_read(6'd0, d, done);
        checks++; if (late !== 0 || d !== 32'h0) $display("FAIL no_rearm got int_cycles=%0d pending=%h want 0/0", late, d); else passed++;
    endtask

    task automatic test_mask();
        logic [31:0] d;
        logic        done;
        int          seen;
        seen = 0;
        do_write(6'd2, 64'h0);
        count[159:128] = 32'd55;
        do_write(6'd40, 64'd55);
        tick();
        if (interrupt) seen++;
        do_read(6'd0, d, done);
        if (interrupt) seen++;
        checks++; if (d !== 32'h10) $display("FAIL masked_pending got %h want 00000010", d); else passed++;
        checks++; if (seen !== 0) $display("FAIL masked_interrupt got %0d high cycles want 0", seen); else passed++;
        do_write(6'd2, 64'h11);
    endtask

    task automatic test_clear_race();
        logic [31:0] d;
        logic        done;
        count[31:0] = 32'd0;
        do_write(6'd32, 64'd7);
        count[31:0] = 32'd7;
        do_read(6'd0, d, done);
        checks++; if (d !== 32'h00) $display("FAIL race_first_read got %h want 0", d); else passed++;
        do_read(6'd0, d, done);
        checks++; if (d !== 32'h01) $display("FAIL race_second_read got %h want 00000001", d); else passed++;
        interrupt_rdy = 1'b1;
        tick();
        interrupt_rdy = 1'b0;
    endtask

    task automatic test_width();
        logic [31:0] d;
        logic        done;
        count[31:0] = 32'h4000_0020;
        do_write(6'd32, 64'hFFFF_FFFF_E000_0020);
        tick();
        do_read(6'd0, d, done);
        checks++; if (d !== 32'h01) $display("FAIL upper_bits_compare got %h want 00000001", d); else passed++;
        do_read(6'd32, d, done);
        checks++; if (d !== 32'h4000_0020) $display("FAIL count_read got %h want 40000020", d); else passed++;
        interrupt_rdy = 1'b1;
        tick();
        interrupt_rdy = 1'b0;
    endtask

    task automatic test_coincide();
        logic [31:0] d;
        logic        done;
        count[31:0] = 32'd9;
        do_write(6'd32, 64'd9);
        interrupt_rdy = 1'b1;
        tick();
        checks++; if (interrupt !== 1'b1) $display("FAIL event_with_rdy got %b want 1", interrupt); else passed++;
        tick();
        interrupt_rdy = 1'b0;
        checks++; if (interrupt !== 1'b0) $display("FAIL rdy_release got %b want 0", interrupt); else passed++;
        do_read(6'd0, d, done);
    endtask

    task automatic test_disabled();
        logic [31:0] d;
        logic        done;
        count[63:32] = 32'd5;
        do_write(6'd34, 64'd5);
        tick();
        do_read(6'd0, d, done);
        checks++; if (d !== 32'h0) $display("FAIL disabled_pending got %h want 0", d); else passed++;
        do_read(6'd34, d, done);
        checks++; if (d !== 32'h0) $display("FAIL disabled_count got %h want 0", d); else passed++;
        do_read(6'd5, d, done);
        checks++; if (d !== 32'h0002_0008) $display("FAIL id_reg got %h want 00020008", d); else passed++;
        do_read(6'd63, d, done);
        checks++; if (d !== 32'h0) $display("FAIL unmapped_read got %h want 0", d); else passed++;
        do_read(6'd1, d, done);
        checks++; if (d !== 32'h11) $display("FAIL enable_reg got %h want 00000011", d); else passed++;
    endtask

    task automatic test_same_cycle_rw();
        logic [31:0] d;
        logic        done;
        pio_wvalid = 1'b1;
        pio_rvalid = 1'b1;
        pio_addr   = 6'd2;
        pio_wdata  = 64'h01;
        tick();
        pio_wvalid = 1'b0;
        pio_rvalid = 1'b0;
        checks++; if (rc_data !== 32'h11) $display("FAIL rw_pre_value got %h want 00000011", rc_data); else passed++;
        do_read(6'd2, d, done);
        checks++; if (d !== 32'h01) $display("FAIL rw_post_value got %h want 00000001", d); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        done;
        int          pulses;
        pulses = 0;
        do_write(6'd4, 64'hFF);
        count[31:0] = 32'd33;
        do_write(6'd32, 64'd33);
        tick();
        checks++; if (interrupt !== 1'b1) $display("FAIL pre_reset_interrupt got %b want 1", interrupt); else passed++;
        pio_rvalid = 1'b1;
        pio_addr   = 6'd0;
        tick();
        pio_rvalid = 1'b0;
        reset      = 1'b1;
        #1;
        if (rc_done) pulses++;
        tick();
        if (rc_done) pulses++;
        reset = 1'b0;
        checks++; if (interrupt !== 1'b0) $display("FAIL reset_drops_interrupt got %b want 0", interrupt); else passed++;
        checks++; if (fifo_reset !== 8'h11) $display("FAIL reset_mid_fifo_reset got %h want 11", fifo_reset); else passed++;
        tick();
        if (rc_done) pulses++;
        checks++; if (pulses !== 0) $display("FAIL reset_read_done got %0d pulses want 0", pulses); else passed++;
        do_read(6'd2, d, done);
        checks++; if (d !== 32'h11) $display("FAIL reset_mid_mask got %h want 00000011", d); else passed++;
        do_read(6'd0, d, done);
        checks++; if (d !== 32'h0) $display("FAIL reset_mid_pending got %h want 0", d); else passed++;
    endtask

    initial begin
        reset         = 1'b1;
        pio_wvalid    = 1'b0;
        pio_rvalid    = 1'b0;
        pio_addr      = '0;
        pio_wdata     = '0;
        count         = '0;
        interrupt_rdy = 1'b0;
        test_reset();
        test_fifo_reset();
        test_threshold();
        test_mask();
        test_clear_race();
        test_width();
        test_coincide();
        test_disabled();
        test_same_cycle_rw();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
